serial_xor_accum: RTL

SERIAL_XOR_ACCUM -- requirements
Module: serial_xor_accum

---
 rtl/serial_xor_accum.sv | 125 ++++++++++++
 1 files changed

// File: rtl/serial_xor_accum.sv
// serial_xor_accum: collects FRAME_LEN {a,b} bit pairs and keeps a histogram
// of the four pair codes. It also reports how many pairs differed
// (a^b=1), whether every pair matched, and the parity of the difference count.
// Results update once per frame, when the frame completes, and are held
// until the next frame completes.
module serial_xor_accum #(
    parameter int unsigned FRAME_LEN = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic        a,
    input  logic        b,
    output logic        in_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] code_hist,
    output logic [7:0]  mismatch_cnt,
    output logic        match_all,
    output logic        xor_parity
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    // Index of the last pair in a frame. FRAME_LEN is limited to 1..255,
    // so this value and every counter fit in 8 bits.
    localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

    state_t          state_q, state_d;
    logic [7:0]      idx_q, idx_d;
    logic [3:0][7:0] cnt_q, cnt_d;
    logic [31:0]     hist_q, hist_d;
    logic [7:0]      mism_q, mism_d;
    logic            match_q, match_d;
    logic            clear;
    logic            accept;
    logic            last_pair;
    logic [1:0]      code;

    assign code      = {a, b};
    assign accept    = (state_q == S_COLLECT) && in_valid;
    assign last_pair = accept && (idx_q == LAST_IDX);
    assign clear     = (state_q == S_IDLE) && start;

    // One counter per pair code. The code is decoded one-hot, so an
    // accepted pair bumps exactly one counter.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_code_cnt
            assign cnt_d[gi] = clear                          ? 8'd0 :
                               (accept && (code == 2'(gi)))   ? cnt_q[gi] + 8'd1 :
                                                                cnt_q[gi];
        end
    endgenerate

    // Next-state, bit-index and result-capture logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hist_d  = hist_q;
        mism_d  = mism_q;
        match_d = match_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = 8'd0;
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    idx_d = idx_q + 8'd1;
                end
                // Results are captured from the next-count values, so the
                // last pair is included.
                if (last_pair) begin
                    state_d = S_DONE;
                    hist_d  = {cnt_d[3], cnt_d[2], cnt_d[1], cnt_d[0]};
                    mism_d  = cnt_d[1] + cnt_d[2];
                    match_d = ((cnt_d[1] + cnt_d[2]) == 8'd0);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter and result registers. Reset asynchronously clears
    // everything, which also discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 8'd0;
            cnt_q   <= '0;
            hist_q  <= 32'd0;
            mism_q  <= 8'd0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            hist_q  <= hist_d;
            mism_q  <= mism_d;
            match_q <= match_d;
        end
    end

    assign in_ready     = (state_q == S_COLLECT);
    assign busy         = (state_q == S_COLLECT) || (state_q == S_DONE);
    assign done         = (state_q == S_DONE);
    assign code_hist    = hist_q;
    assign mismatch_cnt = mism_q;
    assign match_all    = match_q;
    assign xor_parity   = mism_q[0];

endmodule
